vga_scan_ctrl: RTL and testbench

- Timing sequencer for the Tiny VGA PMOD output path.
- Generates the 640x480@60 raster:
  - horizontal and vertical position counters
  - display-enable, hsync, vsync
  - line and frame strobes, plus a frame counter
- The pixel generator consumes hpos/vpos/frame and produces RGB some cycles later. Sync and enable outputs are re-timed by a configurable pipeline so they line up with the generator's RGB.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_scan_ctrl_if.sv | 35 +++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_scan_ctrl.sv | 87 ++++++++
 tb/tb_vga_scan_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, raster-size helper and per-axis state encoding
// for the 640x480@60 scan controller.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_t;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int h_total(input int active = H_ACTIVE_DEF, input int front = H_FRONT_DEF,
                                 input int sync = H_SYNC_DEF, input int back = H_BACK_DEF);
    return axis_total(active, front, sync, back);
  endfunction

  function automatic int v_total(input int active = V_ACTIVE_DEF, input int front = V_FRONT_DEF,
                                 input int sync = V_SYNC_DEF, input int back = V_BACK_DEF);
    return axis_total(active, front, sync, back);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Scan-controller bundle: the pixel generator side samples positions and strobes,
// the PMOD side takes the re-timed syncs and enable. Axis states are debug taps.
interface vga_scan_ctrl_if;
   import vga_timing_pkg::*;

   // tick_en is a qualifier, not a handshake: the controller advances exactly
   // on cycles where tick_en=1, and there is no back-pressure path.
   logic        tick_en;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        display_on;
   logic        line_start;
   logic        frame_start;
   logic [7:0]  frame;
   logic        hsync_d;
   logic        vsync_d;
   logic        de_d;
   logic        hsync;
   logic        vsync;
   axis_state_t h_state;
   axis_state_t v_state;

   modport master (
      input  tick_en,
      output hpos, vpos, display_on, line_start, frame_start, frame,
      output hsync_d, vsync_d, de_d, hsync, vsync, h_state, v_state
   );

   modport slave (
      output tick_en,
      input  hpos, vpos, display_on, line_start, frame_start, frame,
      input  hsync_d, vsync_d, de_d, hsync, vsync, h_state, v_state
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus a registered ACTIVE/FRONT/SYNC/BACK
// state and its sync level, all advancing together on step.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE   = 640,
   parameter int FRONT    = 16,
   parameter int SYNC     = 96,
   parameter int BACK     = 48,
   parameter bit SYNC_POL = 1'b0,
   parameter int W        = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   output logic [W-1:0] pos,
   output axis_state_t  state,
   output logic         wrap,
   output logic         sync
);

   localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
   localparam logic [W-1:0] END_FRONT  = W'(ACTIVE + FRONT - 1);
   localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FRONT + SYNC - 1);
   localparam logic [W-1:0] END_TOTAL  = W'(TOTAL - 1);

   assign wrap = step && (pos == END_TOTAL);

   // Sync is updated in the same edge as the state so it never lags the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos   <= '0;
         state <= ST_ACTIVE;
         sync  <= ~SYNC_POL;
      end else if (step) begin
         pos <= (pos == END_TOTAL) ? '0 : pos + W'(1);
         unique case (state)
            ST_ACTIVE: if (pos == END_ACTIVE) state <= ST_FRONT;
            ST_FRONT: begin
               if (pos == END_FRONT) begin
                  state <= ST_SYNC;
                  sync  <= SYNC_POL;
               end
            end
            ST_SYNC: begin
               if (pos == END_SYNC) begin
                  state <= ST_BACK;
                  sync  <= ~SYNC_POL;
               end
            end
            ST_BACK: if (pos == END_TOTAL) state <= ST_ACTIVE;
         endcase
      end
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: horizontal/vertical axes, frame counter, strobes and a
// sync/enable delay pipe that aligns with the downstream pixel generator's RGB.
module vga_scan_ctrl
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIPE     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_scan_ctrl_if.master  bus
);

   localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
   localparam logic [2:0] PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

   logic [9:0]  hpos, vpos;
   logic        h_wrap, v_wrap;
   logic        hsync, vsync;
   logic        display_on;
   logic [7:0]  frame;
   axis_state_t h_state, v_state;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
      .SYNC_POL(SYNC_POL), .W(10)
   ) u_h_axis (
      .clk(clk), .rst_n(rst_n), .step(bus.tick_en),
      .pos(hpos), .state(h_state), .wrap(h_wrap), .sync(hsync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
      .SYNC_POL(SYNC_POL), .W(10)
   ) u_v_axis (
      .clk(clk), .rst_n(rst_n), .step(h_wrap),
      .pos(vpos), .state(v_state), .wrap(v_wrap), .sync(vsync)
   );

   assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

   // v_wrap already implies tick_en and the horizontal wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame <= 8'd0;
      else if (v_wrap) frame <= frame + 8'd1;
   end

   generate
      if (PIPE == 0) begin : g_no_pipe
         assign bus.hsync_d = hsync;
         assign bus.vsync_d = vsync;
         assign bus.de_d    = display_on;
      end else begin : g_pipe
         logic [2:0] stage [PIPE];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE; i++) stage[i] <= PIPE_RST;
            end else if (bus.tick_en) begin
               stage[0] <= {hsync, vsync, display_on};
               for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
            end
         end
         assign {bus.hsync_d, bus.vsync_d, bus.de_d} = stage[PIPE-1];
      end
   endgenerate

   assign bus.hpos        = hpos;
   assign bus.vpos        = vpos;
   assign bus.display_on  = display_on;
   assign bus.line_start  = bus.tick_en && (hpos == 10'd0);
   assign bus.frame_start = bus.tick_en && (hpos == 10'd0) && (vpos == 10'd0);
   assign bus.frame       = frame;
   assign bus.hsync       = hsync;
   assign bus.vsync       = vsync;
   assign bus.h_state     = h_state;
   assign bus.v_state     = v_state;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench: full-size raster for line timing, tick gating and async reset;
// a shrunken raster (15x8, active-high sync, no pipe) for frame-level behaviour.
module tb_vga_scan_ctrl;
   import vga_timing_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   vga_scan_ctrl_if a_if ();
   vga_scan_ctrl_if b_if ();

   vga_scan_ctrl #(.SYNC_POL(1'b0), .PIPE(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(a_if)
   );

   vga_scan_ctrl #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_POL(1'b1), .PIPE(0)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_clk();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_if.tick_en = 1'b0;
      b_if.tick_en = 1'b0;
      repeat (3) next_clk();
      n_checks++; if (a_if.hpos !== 10'd0) begin n_fail++; $display("FAIL rst_hpos got=%0d exp=0", a_if.hpos); end
      n_checks++; if (a_if.vpos !== 10'd0) begin n_fail++; $display("FAIL rst_vpos got=%0d exp=0", a_if.vpos); end
      n_checks++; if (a_if.display_on !== 1'b1) begin n_fail++; $display("FAIL rst_display_on got=%b exp=1", a_if.display_on); end
      n_checks++; if (a_if.frame !== 8'd0) begin n_fail++; $display("FAIL rst_frame got=%0d exp=0", a_if.frame); end
      n_checks++; if (a_if.hsync !== 1'b1 || a_if.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_raw_sync got=%b%b exp=11", a_if.hsync, a_if.vsync); end
      n_checks++; if (a_if.hsync_d !== 1'b1 || a_if.vsync_d !== 1'b1) begin n_fail++; $display("FAIL rst_sync_d got=%b%b exp=11", a_if.hsync_d, a_if.vsync_d); end
      n_checks++; if (a_if.de_d !== 1'b0) begin n_fail++; $display("FAIL rst_de_d got=%b exp=0", a_if.de_d); end
      n_checks++; if (a_if.h_state !== ST_ACTIVE || a_if.v_state !== ST_ACTIVE) begin n_fail++; $display("FAIL rst_state got=%0d/%0d exp=0/0", a_if.h_state, a_if.v_state); end
      n_checks++; if (b_if.hsync_d !== 1'b0 || b_if.vsync_d !== 1'b0) begin n_fail++; $display("FAIL rst_small_sync_d got=%b%b exp=00", b_if.hsync_d, b_if.vsync_d); end
      rst_n = 1'b1;
      // tick_en=0 after release: nothing moves and strobes stay low.
      repeat (3) next_clk();
      n_checks++; if (a_if.hpos !== 10'd0) begin n_fail++; $display("FAIL hold_hpos got=%0d exp=0", a_if.hpos); end
      n_checks++; if (a_if.line_start !== 1'b0 || a_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL hold_strobes got=%b%b exp=00", a_if.line_start, a_if.frame_start); end
   endtask

   task automatic test_line();
      int low_cnt;
      logic exp_hs, exp_hs_d, exp_de_d;
      low_cnt = 0;
      a_if.tick_en = 1'b1;
      #1;
      n_checks++; if (a_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL line_first_frame_start got=%b exp=1", a_if.frame_start); end
      for (int i = 0; i < 800; i++) begin
         exp_hs   = (i >= 656 && i <= 751) ? 1'b0 : 1'b1;
         exp_hs_d = (i >= 658 && i <= 753) ? 1'b0 : 1'b1;
         exp_de_d = (i >= 2 && i < 642) ? 1'b1 : 1'b0;
         if (a_if.hsync === 1'b0) low_cnt++;
         n_checks++; if (a_if.hpos !== 10'(i)) begin n_fail++; $display("FAIL line_hpos got=%0d exp=%0d", a_if.hpos, i); end
         n_checks++; if (a_if.vpos !== 10'd0) begin n_fail++; $display("FAIL line_vpos at %0d got=%0d exp=0", i, a_if.vpos); end
         n_checks++; if (a_if.hsync !== exp_hs) begin n_fail++; $display("FAIL line_hsync at %0d got=%b exp=%b", i, a_if.hsync, exp_hs); end
         n_checks++; if (a_if.hsync_d !== exp_hs_d) begin n_fail++; $display("FAIL line_hsync_d at %0d got=%b exp=%b", i, a_if.hsync_d, exp_hs_d); end
         n_checks++; if (a_if.display_on !== (i < 640)) begin n_fail++; $display("FAIL line_display_on at %0d got=%b", i, a_if.display_on); end
         n_checks++; if (a_if.de_d !== exp_de_d) begin n_fail++; $display("FAIL line_de_d at %0d got=%b exp=%b", i, a_if.de_d, exp_de_d); end
         n_checks++; if (a_if.line_start !== (i == 0)) begin n_fail++; $display("FAIL line_start at %0d got=%b", i, a_if.line_start); end
         next_clk();
      end
      n_checks++; if (low_cnt != 96) begin n_fail++; $display("FAIL hsync_low_count got=%0d exp=96", low_cnt); end
      n_checks++; if (a_if.hpos !== 10'd0 || a_if.vpos !== 10'd1) begin n_fail++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", a_if.hpos, a_if.vpos); end
      n_checks++; if (a_if.line_start !== 1'b1 || a_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL line2_strobes got=%b%b exp=10", a_if.line_start, a_if.frame_start); end
   endtask

   task automatic test_tick_toggle();
      int   n;
      logic en;
      logic exp_de_d;
      n = 0;
      for (int c = 0; c < 1400; c++) begin
         en = (c % 2 == 1);
         a_if.tick_en = en;
         #1;
         exp_de_d = (n >= 2 && n < 642) ? 1'b1 : 1'b0;
         n_checks++; if (a_if.hpos !== 10'(n)) begin n_fail++; $display("FAIL tog_hpos clk %0d got=%0d exp=%0d", c, a_if.hpos, n); end
         n_checks++; if (a_if.line_start !== (en && n == 0)) begin n_fail++; $display("FAIL tog_line_start clk %0d got=%b", c, a_if.line_start); end
         n_checks++; if (a_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL tog_frame_start clk %0d got=%b exp=0", c, a_if.frame_start); end
         n_checks++; if (a_if.de_d !== exp_de_d) begin n_fail++; $display("FAIL tog_de_d clk %0d got=%b exp=%b", c, a_if.de_d, exp_de_d); end
         next_clk();
         if (en) n++;
      end
   endtask

   task automatic test_async_reset();
      int budget;
      budget = 0;
      a_if.tick_en = 1'b1;
      while (a_if.hpos !== 10'd300 && budget < 1000) begin
         next_clk();
         budget++;
      end
      n_checks++; if (a_if.hpos !== 10'd300 || a_if.vpos !== 10'd2) begin n_fail++; $display("FAIL seek_300 got=%0d,%0d exp=300,2", a_if.hpos, a_if.vpos); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (a_if.hpos !== 10'd0 || a_if.vpos !== 10'd0) begin n_fail++; $display("FAIL async_pos got=%0d,%0d exp=0,0", a_if.hpos, a_if.vpos); end
      n_checks++; if (a_if.de_d !== 1'b0 || a_if.display_on !== 1'b1) begin n_fail++; $display("FAIL async_de got=%b%b exp=01", a_if.de_d, a_if.display_on); end
      n_checks++; if (a_if.hsync_d !== 1'b1 || a_if.frame !== 8'd0) begin n_fail++; $display("FAIL async_misc got=%b,%0d exp=1,0", a_if.hsync_d, a_if.frame); end
      next_clk();
      next_clk();
      rst_n = 1'b1;
      #1;
      n_checks++; if (a_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL post_rst_frame_start got=%b exp=1", a_if.frame_start); end
      n_checks++; if (a_if.de_d !== 1'b0) begin n_fail++; $display("FAIL post_rst_de_d0 got=%b exp=0", a_if.de_d); end
      next_clk();
      n_checks++; if (a_if.hpos !== 10'd1 || a_if.de_d !== 1'b0) begin n_fail++; $display("FAIL post_rst_tick1 got=%0d/%b exp=1/0", a_if.hpos, a_if.de_d); end
      next_clk();
      n_checks++; if (a_if.hpos !== 10'd2 || a_if.de_d !== 1'b1) begin n_fail++; $display("FAIL post_rst_tick2 got=%0d/%b exp=2/1", a_if.hpos, a_if.de_d); end
      a_if.tick_en = 1'b0;
   endtask

   task automatic test_small_frame();
      int h, v, de_cnt;
      logic exp_de, exp_hs, exp_vs;
      de_cnt = 0;
      b_if.tick_en = 1'b1;
      #1;
      for (int t = 0; t < 120; t++) begin
         h = t % 15;
         v = t / 15;
         exp_de = (h < 8) && (v < 4);
         exp_hs = (h >= 10 && h <= 12);
         exp_vs = (v >= 5 && v <= 6);
         if (b_if.display_on === 1'b1) de_cnt++;
         n_checks++; if (b_if.hpos !== 10'(h) || b_if.vpos !== 10'(v)) begin n_fail++; $display("FAIL sm_pos t=%0d got=%0d,%0d exp=%0d,%0d", t, b_if.hpos, b_if.vpos, h, v); end
         n_checks++; if (b_if.hsync !== exp_hs || b_if.vsync !== exp_vs) begin n_fail++; $display("FAIL sm_sync t=%0d got=%b%b exp=%b%b", t, b_if.hsync, b_if.vsync, exp_hs, exp_vs); end
         n_checks++; if (b_if.hsync_d !== exp_hs || b_if.vsync_d !== exp_vs || b_if.de_d !== exp_de) begin n_fail++; $display("FAIL sm_pipe0 t=%0d got=%b%b%b exp=%b%b%b", t, b_if.hsync_d, b_if.vsync_d, b_if.de_d, exp_hs, exp_vs, exp_de); end
         n_checks++; if (b_if.frame_start !== (t == 0)) begin n_fail++; $display("FAIL sm_frame_start t=%0d got=%b", t, b_if.frame_start); end
         n_checks++; if (b_if.frame !== 8'd0) begin n_fail++; $display("FAIL sm_frame t=%0d got=%0d exp=0", t, b_if.frame); end
         next_clk();
      end
      n_checks++; if (de_cnt != 32) begin n_fail++; $display("FAIL sm_de_count got=%0d exp=32", de_cnt); end
      n_checks++; if (b_if.hpos !== 10'd0 || b_if.vpos !== 10'd0 || b_if.frame !== 8'd1) begin n_fail++; $display("FAIL sm_wrap got=%0d,%0d f=%0d exp=0,0 f=1", b_if.hpos, b_if.vpos, b_if.frame); end
      n_checks++; if (b_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL sm_wrap_frame_start got=%b exp=1", b_if.frame_start); end
   endtask

   task automatic test_frame_wrap();
      repeat (254 * 120) @(posedge clk);
      #2;
      n_checks++; if (b_if.frame !== 8'd255 || b_if.hpos !== 10'd0 || b_if.vpos !== 10'd0) begin n_fail++; $display("FAIL fw_pre got f=%0d %0d,%0d exp f=255 0,0", b_if.frame, b_if.hpos, b_if.vpos); end
      for (int t = 0; t < 120; t++) begin
         n_checks++; if (b_if.frame !== 8'd255 || b_if.hpos !== 10'(t % 15) || b_if.vpos !== 10'(t / 15)) begin n_fail++; $display("FAIL fw_run t=%0d got f=%0d %0d,%0d", t, b_if.frame, b_if.hpos, b_if.vpos); end
         next_clk();
      end
      n_checks++; if (b_if.frame !== 8'd0 || b_if.hpos !== 10'd0 || b_if.vpos !== 10'd0) begin n_fail++; $display("FAIL fw_wrap got f=%0d %0d,%0d exp f=0 0,0", b_if.frame, b_if.hpos, b_if.vpos); end
      n_checks++; if (b_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL fw_frame_start got=%b exp=1", b_if.frame_start); end
      b_if.tick_en = 1'b0;
      repeat (3) next_clk();
      n_checks++; if (b_if.hpos !== 10'd0 || b_if.frame !== 8'd0 || b_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL fw_hold got %0d f=%0d fs=%b exp 0 f=0 fs=0", b_if.hpos, b_if.frame, b_if.frame_start); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_line();
      test_tick_toggle();
      test_async_reset();
      test_small_frame();
      test_frame_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
